// File: rtl/execute_stage_if.sv
// ---------------------------------------------------------------------------
// execute_stage_if
//   Bundles the issue-side and writeback-side handshakes of the execute
//   stage. The issue side is valid/ready with opcode, operands and tag. The
//   writeback side is valid/ready with result, tag and ALU flags. The busy
//   status travels with them.
//
//   modport master : issue/writeback environment (drives in_*, out_ready)
//   modport slave  : execute stage (drives in_ready, out_*, busy)
// ---------------------------------------------------------------------------
interface execute_stage_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAGW-1:0]  in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAGW-1:0]  out_tag;
  logic             out_carry;
  logic             out_overflow;
  logic             out_zero;
  logic             out_negative;

  logic             busy;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag,
           out_carry, out_overflow, out_zero, out_negative, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag,
           out_carry, out_overflow, out_zero, out_negative, busy
  );
endinterface

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   Integer execute stage between decode/issue and writeback. It accepts one
//   operation per in_valid/in_ready handshake and computes it on one shared
//   add/subtract datapath. It presents a registered result with ALU flags.
//   MUL is an iterative shift-and-add that runs for 32 cycles on the same
//   adder.
//
//   Ports:
//     clk    : clock, all state changes on the rising edge
//     reset  : synchronous, active-high
//     bus    : execute_stage_if.slave
//              in_valid/in_ready/in_op/in_a/in_b/in_tag   issue handshake
//              out_valid/out_ready/out_result/out_tag     writeback handshake
//              out_carry/out_overflow/out_zero/out_negative   flags
//              busy                                       multiply in progress
//
//   Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 MUL,
//            111 reserved (result 0, zero flag set).
// ---------------------------------------------------------------------------

// 32-bit add/subtract unit. When sub = 1 it computes a + ~b + 1. In that case
// carry = 1 means that no borrow occurred.
module full32_bit_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  always_comb begin
    b_eff    = sub ? ~b : b;
    total    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum      = total[WIDTH-1:0];
    carry    = total[WIDTH];
    // Signed overflow: both addends have the same sign and the sum sign differs.
    overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end
endmodule

module execute_stage #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  execute_stage_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e state_q, state_d;
  op_e    op;

  // Multiply iteration state
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [4:0]       count_q;
  logic [TAGW-1:0]  mul_tag_q;

  // Output register
  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic [TAGW-1:0]  tag_q;
  logic             carry_q;
  logic             overflow_q;
  logic             zero_q;
  logic             negative_q;

  // Handshake / control
  logic in_ready;
  logic accept;
  logic mul_start;
  logic mul_done;
  logic load_out;

  // Shared adder
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_sub;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;
  logic             add_overflow;

  // Result and flags about to be loaded into the output register
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             overflow_d;

  assign op = op_e'(bus.in_op);

  // -------------------------------------------------------------------------
  // FSM: next state and handshake
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave
    // it unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = 1'b0;
    accept    = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Accept only when the output slot is free or drains this cycle.
        in_ready = (!valid_q || bus.out_ready) && !reset;
        accept   = bus.in_valid && in_ready;
        if (accept && op == OP_MUL) begin
          mul_start = 1'b1;
          state_d   = ST_MUL;
        end
      end
      ST_MUL: begin
        // count = 0 is the 32nd and last iteration. The output slot is free
        // because the accept required it.
        if (count_q == 5'd0) begin
          mul_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Shared adder: the issue operands in IDLE, accumulator + multiplicand in MUL
  // -------------------------------------------------------------------------
  always_comb begin
    if (state_q == ST_MUL) begin
      add_a   = acc_q;
      add_b   = mcand_q;
      add_sub = 1'b0;
    end else begin
      add_a   = bus.in_a;
      add_b   = bus.in_b;
      add_sub = (op == OP_SUB) || (op == OP_SLT);
    end
  end

  full32_bit_adder #(.WIDTH(WIDTH)) u_adder (
    .a        (add_a),
    .b        (add_b),
    .sub      (add_sub),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  assign acc_next = mplier_q[0] ? add_sum : acc_q;

  // -------------------------------------------------------------------------
  // Result selection
  // -------------------------------------------------------------------------
  always_comb begin
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    if (mul_done) begin
      res_d = acc_next;
    end else begin
      case (op)
        OP_ADD, OP_SUB: begin
          res_d      = add_sum;
          carry_d    = add_carry;
          overflow_d = add_overflow;
        end
        OP_AND: res_d = bus.in_a & bus.in_b;
        OP_OR:  res_d = bus.in_a | bus.in_b;
        OP_XOR: res_d = bus.in_a ^ bus.in_b;
        // The signed less-than result is the true sign of a-b, which
        // corrects the sum sign for overflow.
        OP_SLT: res_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_overflow};
        default: res_d = '0;
      endcase
    end
  end

  assign load_out = (accept && op != OP_MUL) || mul_done;

  // -------------------------------------------------------------------------
  // State, multiply datapath and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so that every
    // register samples values from before the clock edge.
    if (reset) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      count_q    <= '0;
      mul_tag_q  <= '0;
      valid_q    <= 1'b0;
      result_q   <= '0;
      tag_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (mul_start) begin
        acc_q     <= '0;
        mcand_q   <= bus.in_a;
        mplier_q  <= bus.in_b;
        count_q   <= 5'd31;
        mul_tag_q <= bus.in_tag;
      end else if (state_q == ST_MUL) begin
        acc_q    <= acc_next;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        if (count_q != 5'd0) begin
          count_q <= count_q - 5'd1;
        end
      end

      if (load_out) begin
        valid_q    <= 1'b1;
        result_q   <= res_d;
        tag_q      <= mul_done ? mul_tag_q : bus.in_tag;
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        zero_q     <= (res_d == '0);
        negative_q <= res_d[WIDTH-1];
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = valid_q;
  assign bus.out_result   = result_q;
  assign bus.out_tag      = tag_q;
  assign bus.out_carry    = carry_q;
  assign bus.out_overflow = overflow_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_negative = negative_q;
  assign bus.busy         = (state_q == ST_MUL);

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Directed testbench for execute_stage. Inputs change on the falling edge.
//   Outputs are sampled on the falling edge, away from the active rising edge.
//   The flags are compared as a packed nibble {carry, overflow, zero, negative}.
// ---------------------------------------------------------------------------
module tb_execute_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   bad;
  int   cycles;

  execute_stage_if #(.WIDTH(32), .TAGW(5)) bus ();

  execute_stage #(.WIDTH(32), .TAGW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] res,
                           input logic [4:0] rtag, input logic [3:0] flags);
    check({tag, ".valid"},  32'(bus.out_valid), 32'd1);
    check({tag, ".result"}, bus.out_result, res);
    check({tag, ".tag"},    32'(bus.out_tag), 32'(rtag));
    check({tag, ".flags"},  32'({bus.out_carry, bus.out_overflow, bus.out_zero, bus.out_negative}),
          32'(flags));
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
  endtask

  // Counts falling edges until out_valid is seen. The wait is bounded, and
  // cycles = -1 when the bound expires.
  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst.in_ready",  32'(bus.in_ready), 32'd0);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.busy",      32'(bus.busy), 32'd0);
    check("rst.result",    bus.out_result, 32'd0);
    check("rst.flags",     32'({bus.out_carry, bus.out_overflow, bus.out_zero, bus.out_negative}), 32'd0);
    reset = 1'b0;
    #1 check("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    // ---------------- back-to-back ALU ops ----------------
    issue(3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3);
    @(negedge clk);
    check_out("add_ovf", 32'h8000_0000, 5'd3, 4'b0101);
    issue(3'b001, 32'd5, 32'd5, 5'd4);
    @(negedge clk);
    check_out("sub_zero", 32'h0000_0000, 5'd4, 4'b1010);
    issue(3'b001, 32'd0, 32'd1, 5'd5);
    @(negedge clk);
    check_out("sub_borrow", 32'hFFFF_FFFF, 5'd5, 4'b0001);
    issue(3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 5'd6);
    @(negedge clk);
    check_out("slt_true", 32'h0000_0001, 5'd6, 4'b0000);
    issue(3'b101, 32'h7FFF_FFFF, 32'h8000_0000, 5'd7);
    @(negedge clk);
    check_out("slt_false", 32'h0000_0000, 5'd7, 4'b0010);
    issue(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd8);
    @(negedge clk);
    check_out("and", 32'hF000_F000, 5'd8, 4'b0001);
    issue(3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd9);
    @(negedge clk);
    check_out("or", 32'hFFF0_FFF0, 5'd9, 4'b0001);
    issue(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd10);
    @(negedge clk);
    check_out("xor", 32'h0FF0_0FF0, 5'd10, 4'b0000);
    issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11);
    @(negedge clk);
    check_out("reserved", 32'h0000_0000, 5'd11, 4'b0010);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("drain.out_valid", 32'(bus.out_valid), 32'd0);

    // ---------------- MUL: exact latency and busy window ----------------
    issue(3'b110, 32'h0001_0003, 32'h0002_0005, 5'd12);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!(bus.busy === 1'b1 && bus.in_ready === 1'b0 && bus.out_valid === 1'b0)) bad++;
      // A competing op stays presented. It must not be taken while busy.
      if (i == 0) issue(3'b000, 32'hDEAD_BEEF, 32'h1111_1111, 5'd30);
    end
    check("mul.busy_window_bad_cycles", 32'(bad), 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_out("mul_small", 32'h000B_000F, 5'd12, 4'b0000);
    check("mul_small.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("mul_small.drained", 32'(bus.out_valid), 32'd0);

    issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(cycles);
    check("mul_neg.latency", 32'(cycles), 32'd32);
    check_out("mul_neg", 32'h0000_0001, 5'd13, 4'b0000);
    @(negedge clk);

    // ---------------- backpressure ----------------
    bus.out_ready = 1'b0;
    issue(3'b000, 32'd10, 32'd20, 5'd1);
    @(negedge clk);
    check_out("bp_add", 32'd30, 5'd1, 4'b0000);
    issue(3'b001, 32'd100, 32'd1, 5'd2);
    #1 check("bp.in_ready_low", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check_out("bp_add_held", 32'd30, 5'd1, 4'b0000);
    check("bp.in_ready_still_low", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1 check("bp.in_ready_on_drain", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check_out("bp_sub", 32'd99, 5'd2, 4'b1000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.drained", 32'(bus.out_valid), 32'd0);

    // ---------------- reset with a pending output ----------------
    bus.out_ready = 1'b0;
    issue(3'b000, 32'd1, 32'd1, 5'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("pend.valid_before_reset", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("pend.valid_discarded", 32'(bus.out_valid), 32'd0);
    check("pend.result_cleared", bus.out_result, 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;

    // ---------------- reset in the middle of a MUL ----------------
    issue(3'b110, 32'd3, 32'd5, 5'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort.busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.out_valid", 32'(bus.out_valid), 32'd0);
    check("abort.in_ready_in_reset", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check("abort.in_ready_after", 32'(bus.in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    check("abort.no_stale_product", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
